// File: rtl/rgbw_pkg.sv
// Shared definitions for the RGB -> GRBW LED path (channel/word widths, field
// offsets and the word packer used by rgb_2_rgbw_conv and rgb_sotp).
package rgbw_pkg;

   localparam int unsigned CH_W   = 8;
   localparam int unsigned WORD_W = 32;

   localparam int unsigned G_OFF = 24;
   localparam int unsigned R_OFF = 16;
   localparam int unsigned B_OFF = 8;
   localparam int unsigned W_OFF = 0;

   typedef struct packed {
      logic [CH_W-1:0] r;
      logic [CH_W-1:0] g;
      logic [CH_W-1:0] b;
   } rgb_t;

   function automatic logic [WORD_W-1:0] pack_grbw(input logic [CH_W-1:0] g,
                                                  input logic [CH_W-1:0] r,
                                                  input logic [CH_W-1:0] b,
                                                  input logic [CH_W-1:0] w);
      return {g, r, b, w};
   endfunction

endpackage

// File: rtl/rgbw_min3.sv
// Registered minimum of three channels; loads when en is high, holds otherwise.
module rgbw_min3
   import rgbw_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [CH_W-1:0] a,
   input  logic [CH_W-1:0] b,
   input  logic [CH_W-1:0] c,
   output logic [CH_W-1:0] min_q
);

   logic [CH_W-1:0] ab_min;
   logic [CH_W-1:0] min_d;

   always_comb begin
      ab_min = (a < b) ? a : b;
      min_d  = min_q;
      if (en) begin
         min_d = (ab_min < c) ? ab_min : c;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         min_q <= '0;
      end else begin
         min_q <= min_d;
      end
   end

endmodule

// File: rtl/rgb_2_rgbw_conv.sv
// Two-stage RGB -> GRBW converter feeding the LED FIFO, with white extraction,
// full-stall handling and per-string LED counting.
module rgb_2_rgbw_conv
   import rgbw_pkg::*;
#(
   parameter int NUM_LEDS     = 8,
   parameter int CNT_W        = 16,
   parameter bit DEF_WHITE_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [23:0]      in_rgb,
   input  logic             in_sos,
   input  logic             in_white_en,
   output logic             out_ready,
   input  logic             in_wr_fifo_full,
   output logic             out_wr_fifo_en,
   output logic [31:0]      out_wr_fifo_data,
   output logic             out_string_done,
   output logic [CNT_W-1:0] out_led_count
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_LEDS - 1);
   localparam logic [CNT_W-1:0] SOS_CNT  = (NUM_LEDS == 1) ? '0 : CNT_W'(1);

   rgb_t px;
   logic adv;
   logic wr_en;

   logic             s1_valid_q, s1_valid_d;
   logic [CH_W-1:0]  s1_r_q, s1_r_d;
   logic [CH_W-1:0]  s1_g_q, s1_g_d;
   logic [CH_W-1:0]  s1_b_q, s1_b_d;
   logic             s1_sos_q, s1_sos_d;
   logic             s1_wen_q, s1_wen_d;
   logic [CH_W-1:0]  s1_min_q;

   logic              s2_valid_q, s2_valid_d;
   logic              s2_sos_q, s2_sos_d;
   logic [WORD_W-1:0] s2_word_q, s2_word_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [CH_W-1:0] w_s;
   logic [CH_W-1:0] r_s;
   logic [CH_W-1:0] g_s;
   logic [CH_W-1:0] b_s;

   always_comb begin
      px    = rgb_t'(in_rgb);
      adv   = !(s2_valid_q && in_wr_fifo_full);
      wr_en = s2_valid_q && !in_wr_fifo_full;
   end

   rgbw_min3 u_min3 (
      .clk   (clk),
      .rst   (rst),
      .en    (adv),
      .a     (px.r),
      .b     (px.g),
      .c     (px.b),
      .min_q (s1_min_q)
   );

   // Subtracting W from every channel covers pass-through too, since W is 0 there.
   always_comb begin
      w_s = s1_wen_q ? s1_min_q : '0;
      r_s = s1_r_q - w_s;
      g_s = s1_g_q - w_s;
      b_s = s1_b_q - w_s;
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_r_d     = s1_r_q;
      s1_g_d     = s1_g_q;
      s1_b_d     = s1_b_q;
      s1_sos_d   = s1_sos_q;
      s1_wen_d   = s1_wen_q;
      s2_valid_d = s2_valid_q;
      s2_sos_d   = s2_sos_q;
      s2_word_d  = s2_word_q;
      if (adv) begin
         s1_valid_d = in_valid;
         s1_r_d     = px.r;
         s1_g_d     = px.g;
         s1_b_d     = px.b;
         s1_sos_d   = in_sos;
         s1_wen_d   = in_white_en;
         s2_valid_d = s1_valid_q;
         s2_sos_d   = s1_sos_q;
         s2_word_d  = pack_grbw(g_s, r_s, b_s, w_s);
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (wr_en) begin
         if (s2_sos_q) begin
            cnt_d = SOS_CNT;
         end else if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_r_q     <= '0;
         s1_g_q     <= '0;
         s1_b_q     <= '0;
         s1_sos_q   <= 1'b0;
         s1_wen_q   <= DEF_WHITE_EN;
         s2_valid_q <= 1'b0;
         s2_sos_q   <= 1'b0;
         s2_word_q  <= '0;
         cnt_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_r_q     <= s1_r_d;
         s1_g_q     <= s1_g_d;
         s1_b_q     <= s1_b_d;
         s1_sos_q   <= s1_sos_d;
         s1_wen_q   <= s1_wen_d;
         s2_valid_q <= s2_valid_d;
         s2_sos_q   <= s2_sos_d;
         s2_word_q  <= s2_word_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      out_ready        = adv;
      out_wr_fifo_en   = wr_en;
      out_wr_fifo_data = s2_word_q;
      out_string_done  = wr_en && ((cnt_q == LAST_CNT) || (s2_sos_q && (NUM_LEDS == 1)));
      out_led_count    = cnt_q;
   end

endmodule

// File: tb/tb_rgb_2_rgbw_conv.sv
// Directed bench for rgb_2_rgbw_conv (NUM_LEDS = 3) with hand-computed GRBW words.
module tb_rgb_2_rgbw_conv;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [23:0] in_rgb;
   logic        in_sos;
   logic        in_white_en;
   logic        out_ready;
   logic        in_wr_fifo_full;
   logic        out_wr_fifo_en;
   logic [31:0] out_wr_fifo_data;
   logic        out_string_done;
   logic [15:0] out_led_count;

   int checks   = 0;
   int failures = 0;

   logic [31:0] wr_data_q[$];
   logic        wr_done_q[$];

   always #5 clk = ~clk;

   rgb_2_rgbw_conv #(
      .NUM_LEDS     (3),
      .CNT_W        (16),
      .DEF_WHITE_EN (1'b1)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .in_rgb           (in_rgb),
      .in_sos           (in_sos),
      .in_white_en      (in_white_en),
      .out_ready        (out_ready),
      .in_wr_fifo_full  (in_wr_fifo_full),
      .out_wr_fifo_en   (out_wr_fifo_en),
      .out_wr_fifo_data (out_wr_fifo_data),
      .out_string_done  (out_string_done),
      .out_led_count    (out_led_count)
   );

   always @(negedge clk) begin
      if (!rst && out_wr_fifo_en) begin
         wr_data_q.push_back(out_wr_fifo_data);
         wr_done_q.push_back(out_string_done);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_one(input string tag, input logic [23:0] rgb, input logic wen,
                           input logic [31:0] exp);
      int n0;
      n0 = wr_data_q.size();
      in_valid    = 1'b1;
      in_rgb      = rgb;
      in_white_en = wen;
      in_sos      = 1'b0;
      #1;
      chk({tag, "_ready"}, 32'(out_ready), 32'd1);
      step();
      in_valid = 1'b0;
      in_rgb   = '0;
      chk({tag, "_en_early"}, 32'(out_wr_fifo_en), 32'd0);
      step();
      chk({tag, "_en"}, 32'(out_wr_fifo_en), 32'd1);
      chk({tag, "_data"}, out_wr_fifo_data, exp);
      step();
      chk({tag, "_en_after"}, 32'(out_wr_fifo_en), 32'd0);
      chk({tag, "_nwr"}, 32'(wr_data_q.size()), 32'(n0 + 1));
   endtask

   task automatic send_stream(input int n, input int sos_idx);
      for (int i = 0; i < n; i++) begin
         in_valid    = 1'b1;
         in_rgb      = 24'h102030;
         in_white_en = 1'b1;
         in_sos      = (i == sos_idx);
         step();
      end
      in_valid = 1'b0;
      in_sos   = 1'b0;
      repeat (4) step();
   endtask

   logic [23:0] px [6];
   logic [31:0] exw [6];
   logic        exd [7];
   int          p;
   logic        acc;
   int          n0;

   initial begin
      px[0] = 24'h102030;  exw[0] = 32'h10002010;
      px[1] = 24'h050A0F;  exw[1] = 32'h05000A05;
      px[2] = 24'h804020;  exw[2] = 32'h20600020;
      px[3] = 24'h00FF80;  exw[3] = 32'hFF008000;
      px[4] = 24'h7F7F7F;  exw[4] = 32'h0000007F;
      px[5] = 24'hC86496;  exw[5] = 32'h00643264;

      rst             = 1'b1;
      in_valid        = 1'b0;
      in_rgb          = '0;
      in_sos          = 1'b0;
      in_white_en     = 1'b1;
      in_wr_fifo_full = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_ready", 32'(out_ready), 32'd1);
      chk("rst_en", 32'(out_wr_fifo_en), 32'd0);
      chk("rst_done", 32'(out_string_done), 32'd0);
      chk("rst_count", 32'(out_led_count), 32'd0);
      chk("rst_data", out_wr_fifo_data, 32'd0);

      send_one("m1_112233", 24'h112233, 1'b1, 32'h11002211);
      send_one("m0_112233", 24'h112233, 1'b0, 32'h22113300);
      send_one("m1_ffffff", 24'hFFFFFF, 1'b1, 32'h000000FF);
      send_one("m1_000000", 24'h000000, 1'b1, 32'h00000000);

      // Six back-to-back pixels; FIFO full for five cycles once the pipe is loaded.
      wr_data_q.delete();
      wr_done_q.delete();
      p = 0;
      for (int c = 0; c < 20; c++) begin
         in_wr_fifo_full = (c >= 3 && c < 8);
         in_valid        = (p < 6);
         in_rgb          = (p < 6) ? px[p] : '0;
         in_white_en     = 1'b1;
         in_sos          = 1'b0;
         #1;
         if (in_wr_fifo_full) begin
            chk("stall_ready", 32'(out_ready), 32'd0);
            chk("stall_en", 32'(out_wr_fifo_en), 32'd0);
            chk("stall_hold", out_wr_fifo_data, exw[1]);
         end
         acc = in_valid && out_ready;
         step();
         if (acc) p++;
      end
      in_valid        = 1'b0;
      in_wr_fifo_full = 1'b0;
      chk("stream_accepted", 32'(p), 32'd6);
      chk("stream_nwr", 32'(wr_data_q.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         chk("stream_word", (i < wr_data_q.size()) ? wr_data_q[i] : 32'hDEADBEEF, exw[i]);
      end

      // String counting, NUM_LEDS = 3, sos on the first pixel.
      rst = 1'b1;
      step();
      rst = 1'b0;
      wr_data_q.delete();
      wr_done_q.delete();
      send_stream(7, 0);
      exd = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      chk("str1_nwr", 32'(wr_done_q.size()), 32'd7);
      for (int i = 0; i < 7; i++) begin
         chk("str1_done", (i < wr_done_q.size()) ? 32'(wr_done_q[i]) : 32'hX, 32'(exd[i]));
      end
      chk("str1_count", 32'(out_led_count), 32'd1);

      // sos on pixel 5 instead: pulse on write 3 only, then restart at 1.
      rst = 1'b1;
      step();
      rst = 1'b0;
      wr_data_q.delete();
      wr_done_q.delete();
      send_stream(6, 4);
      exd = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      chk("str2_nwr", 32'(wr_done_q.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         chk("str2_done", (i < wr_done_q.size()) ? 32'(wr_done_q[i]) : 32'hX, 32'(exd[i]));
      end
      chk("str2_count", 32'(out_led_count), 32'd2);

      // Two pixels in flight (second accepted while full, S2 empty), then reset.
      in_valid    = 1'b1;
      in_rgb      = 24'h0A0B0C;
      in_white_en = 1'b1;
      step();
      in_wr_fifo_full = 1'b1;
      in_rgb          = 24'h0D0E0F;
      #1;
      chk("bubble_ready", 32'(out_ready), 32'd1);
      step();
      in_valid = 1'b0;
      #1;
      chk("inflight_ready", 32'(out_ready), 32'd0);
      n0  = wr_data_q.size();
      rst = 1'b1;
      #1;
      chk("midrst_ready", 32'(out_ready), 32'd1);
      chk("midrst_count", 32'(out_led_count), 32'd0);
      chk("midrst_en", 32'(out_wr_fifo_en), 32'd0);
      step();
      rst             = 1'b0;
      in_wr_fifo_full = 1'b0;
      repeat (4) step();
      chk("midrst_nwr", 32'(wr_data_q.size()), 32'(n0));
      chk("midrst_count_after", 32'(out_led_count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
